// File: rtl/group4_project_system_sysid_checker.sv
// rtl/group4_project_system_sysid_checker.sv - Avalon-MM master that reads and checks the sysid slave.
// Optional retry passes are enabled with `define SYSID_CHECK_RETRY_EN.
module group4_project_system_sysid_checker #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1423087687,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter logic [1:0]  MAX_RETRIES    = 2'd3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        tmo_q, tmo_d;
    logic [31:0] id_val_q, id_val_d;
    logic [31:0] ts_val_q, ts_val_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_hit;
    logic        finish;
    logic        pass_next;
`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0]  retry_q, retry_d;
`else
    logic        unused_max_retries;
    assign unused_max_retries = ^MAX_RETRIES;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            read_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            tmo_q    <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
            cnt_q    <= '0;
`ifdef SYSID_CHECK_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            tmo_q    <= tmo_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
            cnt_q    <= cnt_d;
`ifdef SYSID_CHECK_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    // The edge on which the count would reach TIMEOUT_CYCLES ends the read.
    assign tmo_hit = (cnt_q == (TIMEOUT_CYCLES - 16'd1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        read_d   = read_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        tmo_d    = tmo_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;
        cnt_d    = cnt_q;
        finish   = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
        retry_d  = retry_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    id_ok_d  = 1'b0;
                    ts_ok_d  = 1'b0;
                    tmo_d    = 1'b0;
                    id_val_d = '0;
                    ts_val_d = '0;
                    busy_d   = 1'b1;
                    read_d   = 1'b1;
                    addr_d   = BASE_ADDR;
                    cnt_d    = '0;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_d  = '0;
`endif
                    state_d  = S_ID_REQ;
                end
            end
            S_ID_REQ, S_TS_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (tmo_hit) begin
                    read_d = 1'b0;
                    tmo_d  = 1'b1;
                    finish = 1'b1;
                end else if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = (state_q == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
                end
            end
            S_ID_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (avm_readdatavalid) begin
                    id_val_d = avm_readdata;
                    id_ok_d  = (avm_readdata == EXPECTED_ID);
                    read_d   = 1'b1;
                    addr_d   = BASE_ADDR + 32'd4;
                    cnt_d    = '0;
                    state_d  = S_TS_REQ;
                end else if (tmo_hit) begin
                    tmo_d  = 1'b1;
                    finish = 1'b1;
                end
            end
            S_TS_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (avm_readdatavalid) begin
                    ts_val_d = avm_readdata;
                    ts_ok_d  = (avm_readdata == EXPECTED_TS);
                    finish   = 1'b1;
                end else if (tmo_hit) begin
                    tmo_d  = 1'b1;
                    finish = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pass_next = id_ok_d & ts_ok_d & ~tmo_d;
        if (finish) begin
`ifdef SYSID_CHECK_RETRY_EN
            if (!pass_next && (retry_q < MAX_RETRIES)) begin
                retry_d  = retry_q + 2'd1;
                id_ok_d  = 1'b0;
                ts_ok_d  = 1'b0;
                tmo_d    = 1'b0;
                id_val_d = '0;
                ts_val_d = '0;
                read_d   = 1'b1;
                addr_d   = BASE_ADDR;
                cnt_d    = '0;
                state_d  = S_ID_REQ;
            end else begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = pass_next;
                state_d = S_DONE;
            end
`else
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = pass_next;
            state_d = S_DONE;
`endif
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = tmo_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_group4_project_system_sysid_checker.sv
// tb/tb_group4_project_system_sysid_checker.sv - directed bench for the sysid checker.
module tb_group4_project_system_sysid_checker;

    localparam logic [31:0] GOOD_TS = 32'd1423087687;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] address;
    logic        read;
    logic        wr = 1'b0;
    logic [31:0] rdata = '0;
    logic        rdv = 1'b0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    logic        start_t = 1'b0;
    logic [31:0] address_t;
    logic        read_t;
    logic        wr_t = 1'b0;
    logic [31:0] rdata_t = '0;
    logic        rdv_t = 1'b0;
    logic        busy_t, done_t, pass_t, id_ok_t, ts_ok_t, timeout_t;
    logic [31:0] id_value_t, ts_value_t;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    group4_project_system_sysid_checker dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(address), .avm_read(read), .avm_waitrequest(wr),
        .avm_readdata(rdata), .avm_readdatavalid(rdv),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
    );

    group4_project_system_sysid_checker #(.TIMEOUT_CYCLES(16'd8)) dut_t (
        .clock(clock), .reset_n(reset_n), .start(start_t),
        .avm_address(address_t), .avm_read(read_t), .avm_waitrequest(wr_t),
        .avm_readdata(rdata_t), .avm_readdatavalid(rdv_t),
        .busy(busy_t), .done(done_t), .pass(pass_t), .id_ok(id_ok_t), .ts_ok(ts_ok_t),
        .timeout(timeout_t), .id_value(id_value_t), .ts_value(ts_value_t)
    );

    // Slave model: optional waitrequest on the first read, data one cycle after acceptance.
    logic [31:0] id_ret = 32'd0;
    logic [31:0] ts_ret = GOOD_TS;
    int          ws_left = 0;
    int          id_bad_left = 0;
    int          reads = 0;
    logic [31:0] addr_log [0:7];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        hold_bad = 1'b0;
    logic        ts_issued_t = 1'b0;
    logic        done_prev = 1'b0;
    int          done_rises = 0;

    always @(negedge clock) begin
        if (pend) begin
            rdv = 1'b1;
            if (pend_addr == 32'd0) begin
                if (id_bad_left > 0) begin
                    rdata = 32'h0000_0BAD;
                    id_bad_left = id_bad_left - 1;
                end else begin
                    rdata = id_ret;
                end
            end else begin
                rdata = ts_ret;
            end
        end else begin
            rdv = 1'b0;
            rdata = '0;
        end
        pend = 1'b0;
        if (prev_wr && (read !== 1'b1 || address !== prev_addr)) hold_bad = 1'b1;
        if (read === 1'b1 && reset_n) begin
            if (ws_left > 0) begin
                wr = 1'b1;
                ws_left = ws_left - 1;
            end else begin
                wr = 1'b0;
                pend = 1'b1;
                pend_addr = address;
                if (reads < 8) addr_log[reads] = address;
                reads = reads + 1;
            end
        end else begin
            wr = 1'b0;
        end
        prev_wr = wr;
        prev_addr = address;
        if (read_t === 1'b1 && address_t == 32'd4) ts_issued_t = 1'b1;
        if (done === 1'b1 && !done_prev) done_rises = done_rises + 1;
        done_prev = done;
    end

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, pass, id_ok, ts_ok, timeout, read} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000000", {busy, done, pass, id_ok, ts_ok, timeout, read});
        end
        checks++;
        if (address !== 32'd0 || id_value !== 32'd0 || ts_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_words addr=%h id=%h ts=%h want=0", address, id_value, ts_value);
        end
        @(posedge clock) #2 reset_n = 1'b1;
    endtask

    task automatic test_pass();
        id_ret = 32'd0; ts_ret = GOOD_TS; reads = 0;
        pulse_start();
        repeat (3) @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pass_e3 done=%b busy=%b want done=0 busy=1", done, busy);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL pass_e4 done=%b busy=%b pass=%b want 1 0 1", done, busy, pass);
        end
        checks++;
        if (reads != 2 || addr_log[0] !== 32'd0 || addr_log[1] !== 32'd4) begin
            errors++;
            $display("FAIL pass_reads n=%0d a0=%h a1=%h want 2 0 4", reads, addr_log[0], addr_log[1]);
        end
        checks++;
        if (id_value !== 32'd0 || ts_value !== GOOD_TS || id_ok !== 1'b1 || ts_ok !== 1'b1) begin
            errors++;
            $display("FAIL pass_values id=%h ts=%h ok=%b%b want 0 %h 11", id_value, ts_value, id_ok, ts_ok, GOOD_TS);
        end
    endtask

    task automatic test_ts_mismatch();
        bit ok;
        id_ret = 32'd0; ts_ret = 32'h1234_5678;
        pulse_start();
        wait_done(50, ok);
        checks++;
        if (!ok || id_ok !== 1'b1 || ts_ok !== 1'b0 || pass !== 1'b0 || ts_value !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ts_mismatch done=%b id_ok=%b ts_ok=%b pass=%b ts=%h want 1 1 0 0 12345678",
                     ok, id_ok, ts_ok, pass, ts_value);
        end
        ts_ret = GOOD_TS;
    endtask

    task automatic test_waitrequest();
        bit ok;
        hold_bad = 1'b0; reads = 0; ws_left = 10;
        pulse_start();
        wait_done(100, ok);
        checks++;
        if (!ok || pass !== 1'b1 || reads != 2) begin
            errors++;
            $display("FAIL wait_pass done=%b pass=%b reads=%0d want 1 1 2", ok, pass, reads);
        end
        checks++;
        if (hold_bad !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold unstable=%b want 0", hold_bad);
        end
    endtask

    task automatic test_timeout();
        @(negedge clock) start_t = 1'b1;
        @(negedge clock) start_t = 1'b0;
        repeat (7) @(negedge clock);
        checks++;
        if (done_t !== 1'b0 || busy_t !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early done=%b busy=%b want 0 1", done_t, busy_t);
        end
        @(negedge clock);
        checks++;
        if (done_t !== 1'b1 || timeout_t !== 1'b1 || pass_t !== 1'b0 || id_ok_t !== 1'b0 || read_t !== 1'b0) begin
            errors++;
            $display("FAIL tmo_done done=%b tmo=%b pass=%b id_ok=%b read=%b want 1 1 0 0 0",
                     done_t, timeout_t, pass_t, id_ok_t, read_t);
        end
        rdv_t = 1'b1; rdata_t = 32'hDEAD_BEEF;
        @(negedge clock);
        rdv_t = 1'b0; rdata_t = '0;
        @(negedge clock);
        checks++;
        if (id_value_t !== 32'd0 || ts_value_t !== 32'd0 || done_t !== 1'b1 || ts_issued_t !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late id=%h ts=%h done=%b ts_read=%b want 0 0 1 0",
                     id_value_t, ts_value_t, done_t, ts_issued_t);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_start();
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, id_ok, ts_ok, timeout, read} !== 7'b0 || id_value !== 32'd0 || address !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid flags=%b id=%h addr=%h want 0", {busy, done, pass, id_ok, ts_ok, timeout, read},
                     id_value, address);
        end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        reads = 0;
        pulse_start();
        wait_done(50, ok);
        checks++;
        if (!ok || pass !== 1'b1 || reads != 2 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_clean done=%b pass=%b reads=%0d tmo=%b want 1 1 2 0", ok, pass, reads, timeout);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        reads = 0;
        @(negedge clock) start = 1'b1;
        wait_done(50, ok);
        @(negedge clock);
        checks++;
        if (!ok || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_retrigger first=%b done=%b busy=%b want 1 0 1", ok, done, busy);
        end
        wait_done(50, ok);
        start = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (!ok || done !== 1'b1 || pass !== 1'b1 || reads != 4) begin
            errors++;
            $display("FAIL b2b_second done=%b pass=%b reads=%0d want 1 1 4", done, pass, reads);
        end
    endtask

`ifdef SYSID_CHECK_RETRY_EN
    task automatic test_retry();
        bit ok;
        int rises0;
        reads = 0; id_bad_left = 2;
        rises0 = done_rises;
        pulse_start();
        wait_done(200, ok);
        @(negedge clock);
        checks++;
        if (!ok || pass !== 1'b1 || reads != 6 || done_rises - rises0 != 1) begin
            errors++;
            $display("FAIL retry done=%b pass=%b reads=%0d rises=%0d want 1 1 6 1",
                     ok, pass, reads, done_rises - rises0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_ts_mismatch();
        test_waitrequest();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef SYSID_CHECK_RETRY_EN
        test_retry();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
